// File: rtl/vproc_mul_arbiter_if.sv
// rtl/vproc_mul_arbiter_if.sv - request, result and multiplier-block bundle of vproc_mul_arbiter
interface vproc_mul_arbiter_if #(
  parameter int REQ_CNT = 2
);
  localparam int IDW = $clog2(REQ_CNT);

  logic [REQ_CNT-1:0]    req_valid_i;
  logic [REQ_CNT-1:0]    req_ready_o;
  logic [REQ_CNT*17-1:0] req_op1_i;
  logic [REQ_CNT*17-1:0] req_op2_i;
  logic [REQ_CNT*16-1:0] req_acc_i;
  logic [REQ_CNT-1:0]    req_acc_flag_i;
  logic [REQ_CNT-1:0]    req_acc_sub_i;

  logic [16:0]           mul_op1_o;
  logic [16:0]           mul_op2_o;
  logic [15:0]           mul_acc_o;
  logic                  mul_acc_flag_o;
  logic                  mul_acc_sub_o;
  logic [32:0]           mul_res_i;

  logic                  res_valid_o;
  logic                  res_ready_i;
  logic [IDW-1:0]        res_id_o;
  logic [32:0]           res_o;

  modport master (
    output req_valid_i, req_op1_i, req_op2_i, req_acc_i, req_acc_flag_i, req_acc_sub_i,
    output mul_res_i, res_ready_i,
    input  req_ready_o, mul_op1_o, mul_op2_o, mul_acc_o, mul_acc_flag_o, mul_acc_sub_o,
    input  res_valid_o, res_id_o, res_o
  );

  modport slave (
    input  req_valid_i, req_op1_i, req_op2_i, req_acc_i, req_acc_flag_i, req_acc_sub_i,
    input  mul_res_i, res_ready_i,
    output req_ready_o, mul_op1_o, mul_op2_o, mul_acc_o, mul_acc_flag_o, mul_acc_sub_o,
    output res_valid_o, res_id_o, res_o
  );
endinterface

// File: rtl/vproc_mul_arbiter.sv
// rtl/vproc_mul_arbiter.sv - credit-gated sharing of one vproc_mul_block among REQ_CNT requesters
// Round-robin arbitration when VPROC_MUL_ARB_RR_EN is defined, fixed lowest-index priority otherwise.
module vproc_mul_arbiter #(
  parameter int REQ_CNT = 2,
  parameter int BUF_OPS = 1,
  parameter int BUF_MUL = 1,
  parameter int BUF_RES = 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  vproc_mul_arbiter_if.slave bus
);
  localparam int L   = BUF_OPS + BUF_MUL + BUF_RES;
  localparam int D   = L + 1;
  localparam int IDW = $clog2(REQ_CNT);
  localparam int CW  = $clog2(D + 1);
  localparam int PW  = (D > 1) ? $clog2(D) : 1;

  logic [CW-1:0]  cnt;
  logic           found;
  logic [IDW-1:0] gnt_idx;
  logic           issue;
  logic           pop;
  logic           fifo_wr;
  logic [IDW-1:0] wr_id;
  logic [REQ_CNT-1:0] ready;

  logic [16:0] sel_op1;
  logic [16:0] sel_op2;
  logic [15:0] sel_acc;
  logic        sel_flag;
  logic        sel_sub;

  logic [32:0]    mem_res [D];
  logic [IDW-1:0] mem_id  [D];
  logic [PW-1:0]  wptr;
  logic [PW-1:0]  rptr;
  logic [CW-1:0]  occ;

`ifdef VPROC_MUL_ARB_RR_EN
  logic [IDW-1:0] ptr;
  logic [IDW:0]   cand;

  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < REQ_CNT; k++) begin
      cand = {1'b0, ptr} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(REQ_CNT)) cand = cand - (IDW+1)'(REQ_CNT);
      if (!found && bus.req_valid_i[cand[IDW-1:0]]) begin
        found   = 1'b1;
        gnt_idx = cand[IDW-1:0];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr <= '0;
    end else if (issue) begin
      ptr <= (gnt_idx == IDW'(REQ_CNT - 1)) ? '0 : gnt_idx + IDW'(1);
    end
  end
`else
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    for (int k = REQ_CNT - 1; k >= 0; k--) begin
      if (bus.req_valid_i[k]) begin
        found   = 1'b1;
        gnt_idx = IDW'(k);
      end
    end
  end
`endif

  // A pop in the same cycle frees a credit, so issue never bubbles at full throughput.
  assign pop   = bus.res_valid_o && bus.res_ready_i;
  assign issue = rst_ni && found && ((cnt < CW'(D)) || pop);

  always_comb begin
    ready = '0;
    if (issue) ready[gnt_idx] = 1'b1;
  end
  assign bus.req_ready_o = ready;

  always_comb begin
    sel_op1  = '0;
    sel_op2  = '0;
    sel_acc  = '0;
    sel_flag = 1'b0;
    sel_sub  = 1'b0;
    for (int k = 0; k < REQ_CNT; k++) begin
      if (issue && gnt_idx == IDW'(k)) begin
        sel_op1  = bus.req_op1_i[17*k +: 17];
        sel_op2  = bus.req_op2_i[17*k +: 17];
        sel_acc  = bus.req_acc_i[16*k +: 16];
        sel_flag = bus.req_acc_flag_i[k];
        sel_sub  = bus.req_acc_sub_i[k];
      end
    end
  end

  assign bus.mul_op1_o = sel_op1;
  assign bus.mul_op2_o = sel_op2;

  // The block consumes the accumulator after its operand buffer, so it lags the operands.
  generate
    if (BUF_OPS != 0) begin : g_acc_reg
      logic [15:0] acc_q;
      logic        flag_q;
      logic        sub_q;
      always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
          acc_q  <= '0;
          flag_q <= 1'b0;
          sub_q  <= 1'b0;
        end else begin
          acc_q  <= sel_acc;
          flag_q <= sel_flag;
          sub_q  <= sel_sub;
        end
      end
      assign bus.mul_acc_o      = acc_q;
      assign bus.mul_acc_flag_o = flag_q;
      assign bus.mul_acc_sub_o  = sub_q;
    end else begin : g_acc_comb
      assign bus.mul_acc_o      = sel_acc;
      assign bus.mul_acc_flag_o = sel_flag;
      assign bus.mul_acc_sub_o  = sel_sub;
    end
  endgenerate

  generate
    if (L == 0) begin : g_tag_none
      assign fifo_wr = issue;
      assign wr_id   = gnt_idx;
    end else begin : g_tag_pipe
      logic [L-1:0]   tag_v;
      logic [IDW-1:0] tag_id [L];
      always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
          tag_v <= '0;
        end else begin
          tag_v[0]  <= issue;
          tag_id[0] <= gnt_idx;
          for (int k = 1; k < L; k++) begin
            tag_v[k]  <= tag_v[k-1];
            tag_id[k] <= tag_id[k-1];
          end
        end
      end
      assign fifo_wr = tag_v[L-1];
      assign wr_id   = tag_id[L-1];
    end
  endgenerate

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(D - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
      cnt  <= '0;
    end else begin
      if (fifo_wr) begin
        mem_res[wptr] <= bus.mul_res_i;
        mem_id[wptr]  <= wr_id;
        wptr          <= ptr_inc(wptr);
      end
      if (pop) rptr <= ptr_inc(rptr);
      case ({fifo_wr, pop})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: ;
      endcase
      case ({issue, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: ;
      endcase
    end
  end

  assign bus.res_valid_o = (occ != '0);
  assign bus.res_o       = mem_res[rptr];
  assign bus.res_id_o    = mem_id[rptr];

  assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(fifo_wr && !pop && occ == CW'(D)));
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(bus.req_ready_o));
endmodule

// File: doc/vproc_mul_arbiter.md
# vproc_mul_arbiter

Shares one `vproc_mul_block` multiply-accumulate instance among `REQ_CNT` requesters inside the vector multiply unit. Grants at most one operation per cycle and drives the block's operand and accumulator inputs with the timing the block requires. Tags each issued operation and returns its 33-bit result to the issuing requester through a small result FIFO. Issue is credit-gated, so results are never lost even though the multiplier pipeline cannot stall.

## Interface
- `REQ_CNT`, 2: number of requesters, 2..8.
- `BUF_OPS`, 1: must equal the connected block's `BUF_OPS`.
- `BUF_MUL`, 1: must equal the connected block's `BUF_MUL`.
- `BUF_RES`, 1: must equal the connected block's `BUF_RES`.
- Derived values:
  - `L = BUF_OPS + BUF_MUL + BUF_RES` (multiplier latency, 0..3).
  - `D = L + 1` (FIFO depth and credit limit).
  - `IDW = $clog2(REQ_CNT)`.
- Ports:
  - `clk_i  in  1  clock`
  - `rst_ni  in  1  reset, synchronous, active-low`
  - `req_valid_i  in  REQ_CNT  request pending, per requester`
  - `req_ready_o  out  REQ_CNT  grant, one-hot or zero`
  - `req_op1_i  in  REQ_CNT*17  signed operand 1, packed with requester i at [17i+:17]`
  - `req_op2_i  in  REQ_CNT*17  signed operand 2, packed as above`
  - `req_acc_i  in  REQ_CNT*16  accumulator, packed at [16i+:16]`
  - `req_acc_flag_i  in  REQ_CNT  use accumulator`
  - `req_acc_sub_i  in  REQ_CNT  subtract product from accumulator`
  - `mul_op1_o, mul_op2_o  out  17 each  operands to the multiplier block`
  - `mul_acc_o  out  16  accumulator to the multiplier block`
  - `mul_acc_flag_o, mul_acc_sub_o  out  1 each  accumulator controls to the multiplier block`
  - `mul_res_i  in  33  multiplier block result`
  - `res_valid_o  out  1  result available`
  - `res_ready_i  in  1  consumer accepts the result`
  - `res_id_o  out  IDW  index of the requester that issued the result`
  - `res_o  out  33  result value`

## Operation
- **Handshake.** Issue of requester i occurs when `req_valid_i[i] && req_ready_o[i]`.
  - `req_ready_o` is combinational from `req_valid_i`, the arbitration pointer and the credit state.
  - A requester must hold its operands stable while its valid is high and ungranted.
- **Credit counter `cnt`** (0..D) counts in-flight operations plus FIFO occupancy.
  - Issue is allowed only when `cnt < D`.
  - Issue increments `cnt`; a pop (`res_valid_o && res_ready_i`) decrements it.
  - A simultaneous issue and pop leaves `cnt` unchanged.
- **Operand path.**
  - `mul_op1_o`/`mul_op2_o` carry the granted requester's operands in the issue cycle; they are 0 when nothing is issued.
  - `mul_acc_o`, `mul_acc_flag_o` and `mul_acc_sub_o` are delayed by `BUF_OPS` cycles (one register stage when `BUF_OPS=1`). They are captured in the issue cycle from the same requester.
  - Flag and sub are 0 for a non-issue slot.
- **Tag pipeline.** A (valid, id) shift register of length `L` tracks each issued operation.
  - When its entry exits, `mul_res_i` is written into the FIFO together with the id.
  - For `L=0` the write happens in the issue cycle.
- **Result FIFO.** Depth `D`, circular read/write pointers plus an occupancy count.
  - `res_valid_o` = FIFO not empty; `res_o`/`res_id_o` show the FIFO head.
  - Write and read in the same cycle are both performed.
  - The FIFO cannot overflow because of credit gating; overflow is an assertion failure.
- **Arbitration.** See Configuration. The pointer updates only on an issue.
- **Reset.** Clears all state: `cnt`=0, FIFO empty, tags invalid, pointer 0. In-flight results are discarded.
- **Reset output values.**
  - `req_ready_o`=0.
  - `res_valid_o`=0.
  - `mul_*_o`=0.
  - `res_o` and `res_id_o` are unspecified while `res_valid_o`=0.

## Timing
- Issue at cycle t; the result is written to the FIFO at edge t+L; `res_valid_o` rises at t+L+1 when the FIFO was empty.
- Throughput is one issue per cycle while the consumer pops every cycle.
- With the consumer stalled, issue stops once `cnt = D`. It resumes in the cycle a pop occurs, because a same-cycle pop frees a credit.
- Results are returned in issue order, across all requesters.

## Configuration
- `VPROC_MUL_ARB_RR_EN` defined:
  - Round-robin arbitration; the search starts at the pointer.
  - After an issue by requester i, the pointer becomes (i+1) mod `REQ_CNT`.
- `VPROC_MUL_ARB_RR_EN` undefined:
  - Fixed priority; the lowest valid index wins.
  - The pointer register is omitted.

## Test plan
- **Single operation.** `L=3`, one operation: requester 0 issues op1=3, op2=-2, acc=10, flag=1, sub=0. Required: `res_valid_o` rises 4 cycles after issue with `res_o`=4 and `res_id_o`=0.
- **Round-robin fairness** (`RR_EN` defined). Both requesters hold valid for 6 cycles with `res_ready_i`=1. Required: grants alternate 0,1,0,1,0,1 and results return in the same order.
- **Fixed priority** (`RR_EN` undefined). Same stimulus. Required: requester 0 is granted all 6 cycles and requester 1 never until 0 drops valid.
- **Backpressure.** `res_ready_i`=0 with continuous requests. Required: exactly `D`=4 issues occur, then `req_ready_o`=0. Raising `res_ready_i` gives one issue per pop, and no result is lost or duplicated.
- **Subtract and no-accumulate paths.**
  - acc=5, flag=1, sub=1, op1=op2=2: required result is 1.
  - flag=0, op1=-1, op2=-1: required result is 1 (accumulator ignored).
  - Repeat both for `L=0` and `L=3`.
- **Reset mid-operation.** Assert `rst_ni`=0 for one cycle with 2 operations in flight and 1 operation in the FIFO. Required: the next cycle `res_valid_o`=0 and `cnt`=0, and no stale result ever appears afterwards.
